och_vc_arbiter_fifo: RTL and testbench
======================================

# och_vc_arbiter_fifo

Parametrised output channel for the virtual-channel router. It arbitrates NUM_IN demultiplexer requesters round-robin, with optional wormhole packet locking, and writes the granted flit into a DEPTH-entry output FIFO. It drives the router output port with a valid flag. It sits between the per-input demux stage and the physical output link; the whole block is clocked by a single clock.

## Interface
Parameters:
- NUM_IN, 4, number of requesting demux ports (2..8)
- FLIT_W, 32, flit width; bits [FLIT_W-2:FLIT_W-3] are the flit type
- DEPTH, 8, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  NUM_IN  request per demux port; held with stable data until granted
- data_in  in  NUM_IN*FLIT_W  flit from port i on bits [i*FLIT_W +: FLIT_W]
- gnt  out  NUM_IN  one-hot (or zero) grant, combinational
- rd_en  in  1  downstream pop request
- data_out  out  FLIT_W  FIFO head, first-word-fall-through
- out_val  out  1  data_out holds a valid flit (FIFO non-empty)
- full  out  1  FIFO holds DEPTH flits
- count  out  $clog2(DEPTH+1)  current FIFO occupancy
- proto_err  out  1  sticky packet-protocol error flag

## Operation
- Flit type: 2'b00 head, 2'b01 body, 2'b10 tail, 2'b11 idle/invalid. Idle flits are never written.
- Arbiter: the round-robin pointer ptr (reset 0) marks the highest-priority port. gnt is the first requesting port searching ptr, ptr+1, ... modulo NUM_IN.
- gnt is forced to all zeros while full=1. There is no write-through-full, even if rd_en is high.
- Transfer: a rising edge with gnt[i]=1 and the selected flit type != 11 writes data_in[i] into the FIFO.
- After a transfer from port i, ptr moves to (i+1) mod NUM_IN.
- A granted idle flit causes no write and no ptr change.
- Lock state (OCH_PKT_LOCK_EN only):
  - States UNLOCKED and LOCKED(owner).
  - A head transfer in UNLOCKED moves to LOCKED(i).
  - In LOCKED, only the owner may be granted. If the owner deasserts req, no grant is issued.
  - A tail transfer from the owner returns to UNLOCKED.
- proto_err sets (sticky until reset) on any of:
  - a body or tail transfer while UNLOCKED;
  - a head transfer while LOCKED.
  - The offending flit is still written.
- FIFO pop: rd_en=1 with out_val=1 removes the head at the edge. rd_en while empty is ignored.
- Simultaneous write and pop: count is unchanged, and pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - gnt=0 while reset is high.
  - data_out=0, out_val=0, full=0, count=0, proto_err=0.
  - ptr=0, lock state UNLOCKED, FIFO pointers 0.
- gnt settles in the same cycle as req/full, with zero-cycle combinational latency.
- Write latency: a flit transferred at edge t appears on data_out with out_val=1 after edge t when the FIFO was empty. Otherwise it appears behind the older entries.
- full rises after the edge that writes entry DEPTH. It falls after the edge of the first pop.
- Reset asserted mid-packet or mid-operation:
  - FIFO contents are discarded.
  - Lock is released and ptr returns to 0.
  - Outputs reach reset values without waiting for a clock edge.
- Throughput: one write and one pop per cycle sustained.

## Configuration
- OCH_PKT_LOCK_EN defined: wormhole locking and proto_err checking as above.
- OCH_PKT_LOCK_EN undefined:
  - Per-flit round-robin; the lock state is absent.
  - proto_err is tied to 0.
  - Flits from different ports may interleave in the FIFO.

## Test plan
- Reset, then req=4'b1111 with all head flits, rd_en=1 held -> gnt order 0,1,2,3,0 on successive transfers (lock off). data_out follows in the same order, one cycle after each write.
- Lock on: port 1 sends head, body, tail while port 2 requests continuously -> port 2 gets no grant until after the tail edge. Then gnt=4'b0100, and the FIFO order is 1H, 1B, 1T, 2x.
- DEPTH=8, rd_en=0, continuous writes -> count reaches 8, full=1, gnt=0. One pop -> full=0 next cycle, and one more write is accepted.
- Lock on: a body flit from port 0 while UNLOCKED -> flit written, and proto_err=1 stays set until reset.
- Granted idle flit (type 2'b11) from port 3 -> no write, count unchanged, ptr unchanged (port 3 still highest priority).
- Reset pulse asserted with count=5 during a locked packet -> out_val=0, count=0, and gnt returns to port-0-first priority immediately after reset is released.

Source files
------------

// File: rtl/och_vc_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : och_vc_arbiter_fifo
// Brief    : Output channel: round-robin arbiter over NUM_IN demux requesters
//            feeding a DEPTH-entry FWFT output FIFO. Define OCH_PKT_LOCK_EN for
//            wormhole packet locking and sticky proto_err checking.
// Revision : 1.0 - initial release
// ============================================================================
module och_vc_arbiter_fifo #(
  parameter int NUM_IN = 4,
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            req,
  input  logic [NUM_IN*FLIT_W-1:0]     data_in,
  output logic [NUM_IN-1:0]            gnt,
  input  logic                         rd_en,
  output logic [FLIT_W-1:0]            data_out,
  output logic                         out_val,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         proto_err
);

  localparam int PTR_W = $clog2(NUM_IN);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [1:0] TYPE_IDLE = 2'b11;

  logic [FLIT_W-1:0] flit [NUM_IN];
  logic [FLIT_W-1:0] fifo_mem_q [DEPTH];

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [PTR_W:0]    cand;
  logic [PTR_W-1:0]  rr_sel, sel;
  logic              rr_found, found, gnt_en, wr_en, pop;
  logic [FLIT_W-1:0] sel_flit;
  logic [1:0]        sel_type;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign flit[gi] = data_in[gi*FLIT_W +: FLIT_W];
    end
  endgenerate

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    cand     = '0;
    for (int k = NUM_IN-1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_IN)) cand = cand - (PTR_W+1)'(NUM_IN);
      if (req[cand[PTR_W-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = cand[PTR_W-1:0];
      end
    end
  end

`ifdef OCH_PKT_LOCK_EN
  localparam logic [1:0] TYPE_HEAD = 2'b00;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t      lock_q, lock_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic             perr_q, perr_d;

  always_comb begin
    if (lock_q == LOCKED) begin
      sel   = owner_q;
      found = req[owner_q];
    end else begin
      sel   = rr_sel;
      found = rr_found;
    end
  end

  // Only the owner can be granted while LOCKED, so sel == owner_q there.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    perr_d  = perr_q;
    if (wr_en) begin
      case (lock_q)
        UNLOCKED: begin
          if (sel_type == TYPE_HEAD) begin
            lock_d  = LOCKED;
            owner_d = sel;
          end else begin
            perr_d  = 1'b1;
          end
        end
        LOCKED: begin
          if (sel_type == TYPE_HEAD)      perr_d = 1'b1;
          else if (sel_type == TYPE_TAIL) lock_d = UNLOCKED;
        end
        default: lock_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q  <= UNLOCKED;
      owner_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      perr_q  <= perr_d;
    end
  end

  assign proto_err = perr_q;
`else
  always_comb begin
    sel   = rr_sel;
    found = rr_found;
  end

  assign proto_err = 1'b0;
`endif

  assign sel_flit = flit[sel];
  assign sel_type = sel_flit[FLIT_W-2:FLIT_W-3];
  assign full     = (count_q == CW'(DEPTH));
  assign out_val  = (count_q != '0);
  assign count    = count_q;
  assign gnt_en   = found && !full && !reset;
  assign gnt      = gnt_en ? (NUM_IN'(1) << sel) : '0;
  assign wr_en    = gnt_en && (sel_type != TYPE_IDLE);
  assign pop      = rd_en && out_val;
  assign data_out = out_val ? fifo_mem_q[rd_ptr_q] : '0;

  always_comb begin
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      ptr_d    = (sel == PTR_W'(NUM_IN-1)) ? '0 : sel + PTR_W'(1);
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (pop && !wr_en) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; out_val gates data_out so stale contents never show.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem_q[wr_ptr_q] <= sel_flit;
  end

endmodule
`default_nettype wire

// File: tb/tb_och_vc_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_och_vc_arbiter_fifo
// Brief    : Scoreboard bench for och_vc_arbiter_fifo (either lock build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_och_vc_arbiter_fifo;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 8;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [N-1:0]               req;
  logic [N*W-1:0]             data_in;
  logic [N-1:0]               gnt;
  logic                       rd_en;
  logic [W-1:0]               data_out;
  logic                       out_val;
  logic                       full;
  logic [$clog2(D+1)-1:0]     count;
  logic                       proto_err;

  och_vc_arbiter_fifo #(.NUM_IN(N), .FLIT_W(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .gnt(gnt),
    .rd_en(rd_en), .data_out(data_out), .out_val(out_val), .full(full),
    .count(count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           m_ptr;
  bit           m_locked;
  int           m_owner;
  bit           m_perr;
  logic [W-1:0] sb [$];
  logic [W-1:0] pq [N][$];
  logic [N-1:0] obs_gnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int port, input int seq);
    return {1'b0, t, 5'd0, port[7:0], seq[15:0]};
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    int idx;
    if (sb.size() == D) return '0;
    if (m_locked) return req[m_owner] ? (N'(1) << m_owner) : '0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) pq[i].delete();
    sb.delete();
    m_ptr = 0; m_locked = 0; m_owner = 0; m_perr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; rd_en = 1'b0; req = '0; data_in = '0;
    reset_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge: drive from the port scripts, check, then advance one edge.
  task automatic tick();
    logic [N-1:0] eg;
    logic [W-1:0] f;
    logic [1:0]   t;
    logic         do_pop;
    int           g;
    for (int i = 0; i < N; i++) begin
      req[i] = (pq[i].size() != 0);
      data_in[i*W +: W] = (pq[i].size() != 0) ? pq[i][0] : '0;
    end
    #1;
    eg = exp_gnt();
    obs_gnt = gnt;
    chk("gnt", gnt, eg);
    chk("out_val", out_val, sb.size() != 0);
    chk("count", count, sb.size());
    chk("full", full, sb.size() == D);
    chk("proto_err", proto_err, m_perr);
    if (sb.size() != 0) chk("data_out", data_out, sb[0]);
    do_pop = rd_en && (sb.size() != 0);
    g = -1;
    for (int i = 0; i < N; i++) if (eg[i]) g = i;
    @(posedge clk);
    if (do_pop) void'(sb.pop_front());
    if (g >= 0) begin
      f = pq[g].pop_front();
      t = f[W-2:W-3];
      if (t != 2'b11) begin
        sb.push_back(f);
        m_ptr = (g + 1) % N;
`ifdef OCH_PKT_LOCK_EN
        if (!m_locked) begin
          if (t == 2'b00) begin m_locked = 1; m_owner = g; end
          else m_perr = 1;
        end else begin
          if (t == 2'b00)      m_perr = 1;
          else if (t == 2'b10) m_locked = 0;
        end
`endif
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0; req = '1; data_in = '0;
    reset_model();
    #2;
    chk("gnt_in_reset", gnt, '0);
    chk("rst_out_val", out_val, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_data_out", data_out, '0);
    chk("rst_perr", proto_err, 1'b0);
    do_reset();

`ifndef OCH_PKT_LOCK_EN
    // Per-flit round robin with all ports holding head flits.
    for (int p = 0; p < N; p++)
      for (int s = 0; s < 2; s++) pq[p].push_back(mk(2'b00, p, s));
    rd_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_order", obs_gnt, N'(1) << (k % N));
    end
    for (int i = 0; i < N; i++) pq[i].delete();
    repeat (2) tick();
`else
    // Port 1 packet holds the lock against port 2.
    do_reset();
    pq[1].push_back(mk(2'b00, 1, 0));
    pq[1].push_back(mk(2'b01, 1, 1));
    pq[1].push_back(mk(2'b10, 1, 2));
    pq[2].push_back(mk(2'b00, 2, 0));
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lock_gnt", obs_gnt, (k < 3) ? 4'b0010 : 4'b0100);
    end
    repeat (3) tick();

    // Body while unlocked: written, sticky error.
    do_reset();
    pq[0].push_back(mk(2'b01, 0, 7));
    rd_en = 1'b1;
    tick(); tick();
    #1 chk("perr_set", proto_err, 1'b1);
    tick(); tick();
    #1 chk("perr_sticky", proto_err, 1'b1);
    reset = 1'b1;
    #1 chk("perr_clear", proto_err, 1'b0);
    @(negedge clk);
`endif

    // Fill to full, pop one, accept exactly one more.
    do_reset();
    pq[0].push_back(mk(2'b00, 0, 0));
    for (int s = 1; s < 10; s++) pq[0].push_back(mk(2'b01, 0, s));
    rd_en = 1'b0;
    repeat (D) tick();
    #1;
    chk("full_count", count, D);
    chk("full_flag", full, 1'b1);
    chk("full_gnt", gnt, '0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    #1;
    chk("pop_unfull", full, 1'b0);
    chk("pop_gnt", gnt, 4'b0001);
    tick();
    #1;
    chk("refill_count", count, D);
    chk("refill_full", full, 1'b1);

    // Granted idle flit: no write and ptr stays on port 3.
    do_reset();
    pq[2].push_back(mk(2'b00, 2, 0));
`ifdef OCH_PKT_LOCK_EN
    pq[2].push_back(mk(2'b10, 2, 1));
`endif
    rd_en = 1'b1;
    while (pq[2].size() != 0) tick();
    rd_en = 1'b0;
    pq[3].push_back(mk(2'b11, 3, 0));
    pq[3].push_back(mk(2'b00, 3, 1));
`ifdef OCH_PKT_LOCK_EN
    pq[3].push_back(mk(2'b10, 3, 2));
`endif
    pq[0].push_back(mk(2'b00, 0, 0));
    tick();
    chk("idle_gnt", obs_gnt, 4'b1000);
    #1 chk("idle_count", count, 1);
    tick();
    chk("idle_ptr_kept", obs_gnt, 4'b1000);
    repeat (3) tick();

    // Async reset in the middle of a packet with five flits queued.
    do_reset();
    pq[1].push_back(mk(2'b00, 1, 0));
    for (int s = 1; s < 7; s++) pq[1].push_back(mk(2'b01, 1, s));
    pq[2].push_back(mk(2'b00, 2, 0));
    rd_en = 1'b0;
    repeat (5) tick();
    #1 chk("pre_reset_count", count, 5);
    #1 reset = 1'b1;
    #1;
    chk("async_out_val", out_val, 1'b0);
    chk("async_count", count, 0);
    chk("async_full", full, 1'b0);
    chk("async_gnt", gnt, '0);
    chk("async_data_out", data_out, '0);
    reset_model();
    @(negedge clk);
    reset = 1'b0;
    for (int p = 0; p < N; p++) pq[p].push_back(mk(2'b00, p, 9));
    tick();
    chk("post_reset_gnt", obs_gnt, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
